pipe_regfile_sb: RTL and testbench
==================================

Name: pipe_regfile_sb

Overview:
Parametrised successor to the core's 32x32 data register file, for the pipelined CPU top. Provides NRD synchronous read ports with same-cycle write-to-read bypass, a hardwired-zero register 0, and a per-register pending-write scoreboard. ID uses the scoreboard to stall on RAW hazards. The WB write port retires pending writes. One instance replaces the plain register file in the CPU top.

Parameters:
XLEN, 32, data width in bits
NREG, 32, number of architectural registers (power of two, >=2)
NRD, 2, number of read ports (1..4)
CNT_W, 2, width of each per-register pending counter (max outstanding writes = 2^CNT_W-1)
AW, $clog2(NREG), address width (derived, not overridden)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset
we  input  1  write/retire strobe from WB
waddr  input  AW  write address
wdata  input  XLEN  write data
re  input  NRD  per-port read enable
raddr  input  NRD*AW  read addresses, port i at [i*AW +: AW]
rdata  output  NRD*XLEN  registered read data, port i at [i*XLEN +: XLEN]
busy  output  NRD  combinational: port i's current raddr has a pending write
issue_valid  input  1  ID issues an instruction that will write issue_rd
issue_rd  input  AW  destination of the issuing instruction
issue_ready  output  1  combinational: the issue can be accepted this cycle

Behaviour:
- Reset (rst=0, async): all registers, all rdata ports and all pending counters go to 0. busy=0. issue_ready=1. Reset mid-operation discards all pending state immediately.
- Write: on a clock edge with we=1 and waddr!=0, reg[waddr]<=wdata. Writes to address 0 are ignored; reg[0] always reads 0.
- Read, 1-cycle latency: on a clock edge with re[i]=1, rdata[i] is loaded.
  - raddr[i]==0 -> 0.
  - else if we && waddr==raddr[i] -> wdata (bypass).
  - else reg[raddr[i]].
  - re[i]=0 -> rdata[i] holds its previous value.
  - All ports are independent; identical addresses on several ports are legal.
- Scoreboard: one counter cnt[r] per register r, r>=1. cnt[0] is constant 0.
  - Issue accepted = issue_valid && issue_ready && issue_rd!=0.
  - Retire = we && waddr!=0.
  - Accepted issue only: cnt+1. Retire only: cnt-1, saturating at 0; a retire with cnt=0 writes data and leaves cnt unchanged. Both on the same register in the same cycle: cnt unchanged. Both on different registers: each counter is updated independently.
- issue_ready = !(cnt[issue_rd]==2^CNT_W-1 && !(retire && waddr==issue_rd)). Issue to register 0 is always ready and is not counted.
- busy[i] = raddr[i]!=0 && cnt[raddr[i]]!=0 && !(retire && waddr==raddr[i] && cnt[raddr[i]]==1).
  - A final retire therefore clears busy in the same cycle, consistent with the bypass.
- busy and issue_ready are purely combinational from current inputs and state. The block inserts no stalls itself.
- Counters never wrap in either direction.

Decomposition:
- Shared package cpu_pkg: XLEN default, AW helper function (clog2), register-0 constant (REG_ZERO).
- Sub-module sb_counter: one saturating up/down CNT_W counter with inc, dec, zero, full and one flags. It is instantiated NREG-1 times by a generate loop.
- Storage, bypass muxes and busy/ready logic stay in the top module.

Test Plan:
- Reset then read: after rst low->high, read all ports at raddr 5 with re=1 -> rdata=0 next cycle, busy=0, issue_ready=1.
- Write/read plus bypass: write 0xDEADBEEF to r3 while port0 raddr=3, re=1 in the same cycle -> rdata[0]=0xDEADBEEF one cycle later. Next cycle port1 reads r3 -> 0xDEADBEEF.
- Zero register: write 0x1234 to r0, then read r0 -> 0. An issue to r0 leaves every counter at 0 and busy stays 0.
- Scoreboard RAW: issue r7, then port0 raddr=7 -> busy[0]=1. Retire we to r7 with 0x55 while reading r7 -> busy[0]=0 that cycle and rdata[0]=0x55 next cycle.
- Saturation (CNT_W=2): issue r9 three times -> issue_ready=0 for issue_rd=9. A 4th issue plus a same-cycle retire of r9 -> accepted, cnt stays 3.
- Async reset mid-operation: with cnt[4]=2 and rdata nonzero, assert rst=0 between clock edges -> rdata=0 and busy=0 immediately. After release, issue_ready=1 for r4.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, register-0 constant and address-width helper for the CPU register file.
package cpu_pkg;
    localparam int XLEN_DEF = 32;
    localparam int REG_ZERO = 0;
    function automatic int clog2(input int n);
        return $clog2(n);
    endfunction
endpackage

// File: rtl/sb_counter.sv
// sb_counter: saturating up/down pending-write counter with zero/one/full flags.
module sb_counter #(
    parameter int W = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic zero,
    output logic one,
    output logic full
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt <= '0;
        else if (inc && !dec && !full) cnt <= cnt + 1'b1;
        else if (dec && !inc && !zero) cnt <= cnt - 1'b1;
    assign zero = cnt == '0;
    assign one  = cnt == W'(1);
    assign full = &cnt;
endmodule

// File: rtl/pipe_regfile_sb.sv
// pipe_regfile_sb: register file with bypassed sync read ports, hardwired r0 and pending-write scoreboard.
module pipe_regfile_sb
    import cpu_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREG  = 32,
    parameter int NRD   = 2,
    parameter int CNT_W = 2,
    parameter int AW    = clog2(NREG)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [XLEN-1:0]       wdata,
    input  logic [NRD-1:0]        re,
    input  logic [NRD*AW-1:0]     raddr,
    output logic [NRD*XLEN-1:0]   rdata,
    output logic [NRD-1:0]        busy,
    input  logic                  issue_valid,
    input  logic [AW-1:0]         issue_rd,
    output logic                  issue_ready
);
    localparam logic [AW-1:0] RZ = AW'(REG_ZERO);
    logic [XLEN-1:0] regs [NREG];
    logic [XLEN-1:0] rd_q [NRD];
    logic [XLEN-1:0] rd_nxt [NRD];
    logic [AW-1:0] ra [NRD];
    logic [NREG-1:0] zero_f, one_f, full_f;
    logic retire, issue_acc;
    assign retire = we && waddr != RZ;
    assign issue_ready = !(full_f[issue_rd] && !(retire && waddr == issue_rd));
    assign issue_acc = issue_valid && issue_ready && issue_rd != RZ;
    // r0 never counts: permanently idle, never full
    assign zero_f[0] = 1'b1;
    assign one_f[0]  = 1'b0;
    assign full_f[0] = 1'b0;
    for (genvar g = 1; g < NREG; g++) begin : g_cnt
        sb_counter #(.W(CNT_W)) u_cnt (
            .clk  (clk),
            .rst  (rst),
            .inc  (issue_acc && issue_rd == AW'(g)),
            .dec  (retire && waddr == AW'(g)),
            .zero (zero_f[g]),
            .one  (one_f[g]),
            .full (full_f[g])
        );
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) for (int r = 0; r < NREG; r++) regs[r] <= '0;
        else if (retire) regs[waddr] <= wdata;
    always_comb begin
        ra = '{default: '0};
        rd_nxt = '{default: '0};
        busy = '0;
        rdata = '0;
        for (int p = 0; p < NRD; p++) begin
            ra[p] = raddr[p*AW +: AW];
            rd_nxt[p] = ra[p] == RZ ? '0 : (retire && waddr == ra[p]) ? wdata : regs[ra[p]];
            busy[p] = !zero_f[ra[p]] && !(retire && waddr == ra[p] && one_f[ra[p]]);
            rdata[p*XLEN +: XLEN] = rd_q[p];
        end
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) for (int p = 0; p < NRD; p++) rd_q[p] <= '0;
        else for (int p = 0; p < NRD; p++) if (re[p]) rd_q[p] <= rd_nxt[p];
endmodule

// File: tb/tb_pipe_regfile_sb.sv
// tb_pipe_regfile_sb: directed vector table, async-reset sequence and random run against a spec-level model.
module tb_pipe_regfile_sb;
    localparam int MAXC = 3;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic [1:0]  re = '0;
    logic [9:0]  raddr = '0;
    logic [63:0] rdata;
    logic [1:0]  busy;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic        issue_ready;
    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] mreg [32];
    int          mcnt [32];
    logic [31:0] mrd [2];
    typedef struct {
        logic we; logic [4:0] wa; logic [31:0] wd; logic [1:0] re;
        logic [4:0] ra0, ra1; logic iv; logic [4:0] ird;
        logic [1:0] busy; logic rdy; logic [31:0] rd0, rd1;
    } vec_t;
    vec_t tbl [15];
    pipe_regfile_sb dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .rdata(rdata), .busy(busy),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready)
    );
    always #5 clk = ~clk;
    function automatic vec_t mk(logic w, logic [4:0] wa, logic [31:0] wd, logic [1:0] r,
                                logic [4:0] a0, logic [4:0] a1, logic iv, logic [4:0] ird,
                                logic [1:0] b, logic rdy, logic [31:0] d0, logic [31:0] d1);
        vec_t v;
        v.we = w; v.wa = wa; v.wd = wd; v.re = r; v.ra0 = a0; v.ra1 = a1; v.iv = iv; v.ird = ird;
        v.busy = b; v.rdy = rdy; v.rd0 = d0; v.rd1 = d1;
        return v;
    endfunction
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin mreg[r] = '0; mcnt[r] = 0; end
        mrd[0] = '0; mrd[1] = '0;
    endtask
    function automatic logic m_busy(logic [4:0] a, logic w, logic [4:0] wa);
        if (a == 0 || mcnt[a] == 0) return 1'b0;
        return !(w && wa == a && mcnt[a] == 1);
    endfunction
    function automatic logic m_ready(logic [4:0] ird, logic w, logic [4:0] wa);
        return !(mcnt[ird] == MAXC && !(w && wa != 0 && wa == ird));
    endfunction
    task automatic model_step(input vec_t v);
        logic ret, acc;
        logic [4:0] a;
        ret = v.we && v.wa != 0;
        acc = v.iv && m_ready(v.ird, v.we, v.wa) && v.ird != 0;
        for (int p = 0; p < 2; p++) if (v.re[p]) begin
            a = p == 0 ? v.ra0 : v.ra1;
            mrd[p] = a == 0 ? 32'h0 : (ret && v.wa == a) ? v.wd : mreg[a];
        end
        if (ret) mreg[v.wa] = v.wd;
        if (!(acc && ret && v.ird == v.wa)) begin
            if (acc) mcnt[v.ird]++;
            if (ret && mcnt[v.wa] > 0) mcnt[v.wa]--;
        end
    endtask
    task automatic run(input vec_t v, input bit mdl);
        we = v.we; waddr = v.wa; wdata = v.wd; re = v.re;
        raddr = {v.ra1, v.ra0}; issue_valid = v.iv; issue_rd = v.ird;
        #1;
        if (mdl) begin
            v.busy = {m_busy(v.ra1, v.we, v.wa), m_busy(v.ra0, v.we, v.wa)};
            v.rdy = m_ready(v.ird, v.we, v.wa);
        end
        chk("busy", 32'(busy), 32'(v.busy));
        chk("issue_ready", 32'(issue_ready), 32'(v.rdy));
        @(posedge clk);
        model_step(v);
        @(negedge clk);
        if (mdl) begin v.rd0 = mrd[0]; v.rd1 = mrd[1]; end
        chk("rdata0", rdata[31:0], v.rd0);
        chk("rdata1", rdata[63:32], v.rd1);
    endtask
    initial begin
        vec_t v;
        tbl[0]  = mk(0, 0, 0,            2'b11, 5, 5, 0, 0, 2'b00, 1, 0,     0);
        tbl[1]  = mk(1, 3, 32'hDEADBEEF, 2'b01, 3, 0, 0, 0, 2'b00, 1, 32'hDEADBEEF, 0);
        tbl[2]  = mk(0, 0, 0,            2'b10, 3, 3, 0, 0, 2'b00, 1, 32'hDEADBEEF, 32'hDEADBEEF);
        tbl[3]  = mk(1, 0, 32'h1234,     2'b11, 0, 3, 1, 0, 2'b00, 1, 0,     32'hDEADBEEF);
        tbl[4]  = mk(0, 0, 0,            2'b00, 7, 9, 1, 7, 2'b00, 1, 0,     32'hDEADBEEF);
        tbl[5]  = mk(0, 0, 0,            2'b00, 7, 3, 0, 0, 2'b01, 1, 0,     32'hDEADBEEF);
        tbl[6]  = mk(1, 7, 32'h55,       2'b01, 7, 3, 0, 0, 2'b00, 1, 32'h55, 32'hDEADBEEF);
        tbl[7]  = mk(0, 0, 0,            2'b00, 7, 9, 1, 9, 2'b00, 1, 32'h55, 32'hDEADBEEF);
        tbl[8]  = mk(0, 0, 0,            2'b00, 7, 9, 1, 9, 2'b10, 1, 32'h55, 32'hDEADBEEF);
        tbl[9]  = mk(0, 0, 0,            2'b00, 7, 9, 1, 9, 2'b10, 1, 32'h55, 32'hDEADBEEF);
        tbl[10] = mk(0, 0, 0,            2'b00, 7, 9, 1, 9, 2'b10, 0, 32'h55, 32'hDEADBEEF);
        tbl[11] = mk(1, 9, 32'hA5,       2'b10, 7, 9, 1, 9, 2'b10, 1, 32'h55, 32'hA5);
        tbl[12] = mk(0, 0, 0,            2'b00, 7, 9, 1, 9, 2'b10, 0, 32'h55, 32'hA5);
        tbl[13] = mk(0, 0, 0,            2'b00, 4, 9, 1, 4, 2'b10, 1, 32'h55, 32'hA5);
        tbl[14] = mk(0, 0, 0,            2'b00, 4, 9, 1, 4, 2'b11, 1, 32'h55, 32'hA5);
        model_reset();
        raddr = {5'd5, 5'd5}; re = 2'b11;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_rdata", rdata[31:0] | rdata[63:32], 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(issue_ready), 1);
        @(negedge clk);
        rst = 1'b1;
        foreach (tbl[k]) run(tbl[k], 1'b0);
        // asynchronous reset between edges with r4/r9 pending and rdata nonzero
        we = 0; re = 0; issue_valid = 0; issue_rd = 5'd9; raddr = {5'd9, 5'd4};
        #2 rst = 1'b0;
        #1;
        chk("arst_rdata0", rdata[31:0], 0);
        chk("arst_rdata1", rdata[63:32], 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_ready9", 32'(issue_ready), 1);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        issue_rd = 5'd4;
        #1;
        chk("post_rst_ready4", 32'(issue_ready), 1);
        chk("post_rst_busy", 32'(busy), 0);
        @(negedge clk);
        for (int n = 0; n < 400; n++) begin
            v = mk($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom, 2'($urandom),
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom_range(0, 2) != 0,
                   5'($urandom_range(0, 7)), 0, 0, 0, 0);
            run(v, 1'b1);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
